input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_conditioner.sv | 104 ++++++++++
 tb/tb_input_conditioner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: conditions one raw asynchronous input.
//   The input is synchronized, then glitch-filtered: a level change is accepted
//   only after FILT_LEN consecutive disagreeing samples. Accepted edges produce
//   one-cycle RISE/FALL strobes, and shorter disagreements are counted as
//   glitches. A timer raises LOS when no edge has been accepted for LOS_CYCLES
//   cycles.
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   IN         raw asynchronous input
//   EN         measurement gate for the pulses and the glitch counter
//   IN_CLEAN   synchronized, filtered level
//   RISE_PULSE one-cycle strobe on an accepted 0->1 change
//   FALL_PULSE one-cycle strobe on an accepted 1->0 change
//   LOS        loss-of-signal flag
//   GLITCH_CNT saturating 8-bit count of rejected glitches
module input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int LOS_CYCLES  = 100000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN,
  input  logic       EN,
  output logic       IN_CLEAN,
  output logic       RISE_PULSE,
  output logic       FALL_PULSE,
  output logic       LOS,
  output logic [7:0] GLITCH_CNT
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TW = $clog2(LOS_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
  localparam logic [TW-1:0] LOS_MAX  = TW'(LOS_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   los_q, los_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [7:0]             gcnt_q, gcnt_d;

  logic s, differ, accept, glitch;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], IN};
    differ  = (s != clean_q);
    accept  = differ && (cnt_q == CNT_LAST);
    // A disagreement run that ends before reaching FILT_LEN is a glitch;
    // accept and glitch therefore can never coincide.
    glitch  = !differ && (cnt_q != '0);

    cnt_d   = (differ && !accept) ? cnt_q + CW'(1) : '0;
    clean_d = accept ? s : clean_q;
    rise_d  = accept &&  s && EN;
    fall_d  = accept && !s && EN;

    gcnt_d  = gcnt_q;
    if (glitch && EN && (gcnt_q != 8'hFF)) gcnt_d = gcnt_q + 8'd1;

    // An accepted edge clears the timer even when it is saturated.
    if (accept)                  timer_d = '0;
    else if (timer_q == LOS_MAX) timer_d = timer_q;
    else                         timer_d = timer_q + TW'(1);

    // LOS registered from the next timer value so it tracks the timer exactly.
    los_d = (timer_d == LOS_MAX);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      los_q   <= 1'b0;
      timer_q <= '0;
      gcnt_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      los_q   <= los_d;
      timer_q <= timer_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign IN_CLEAN   = clean_q;
  assign RISE_PULSE = rise_q;
  assign FALL_PULSE = fall_q;
  assign LOS        = los_q;
  assign GLITCH_CNT = gcnt_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int LOSC = 20;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN  = 1'b0;
  logic       EN  = 1'b1;
  logic       IN_CLEAN, RISE_PULSE, FALL_PULSE, LOS;
  logic [7:0] GLITCH_CNT;

  int n_chk = 0;
  int n_err = 0;

  input_conditioner #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT), .LOS_CYCLES(LOSC)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .EN(EN),
    .IN_CLEAN(IN_CLEAN), .RISE_PULSE(RISE_PULSE), .FALL_PULSE(FALL_PULSE),
    .LOS(LOS), .GLITCH_CNT(GLITCH_CNT)
  );

  always #5 CLK = ~CLK;

  // Reference model: IN delayed through a queue, a disagreement run length,
  // and cycle counters derived directly from the behavioural rules.
  bit m_inq[$];
  bit m_clean, m_rise, m_fall, m_los;
  int m_run, m_timer, m_gc;

  function automatic void model_step();
    bit s;
    if (RST) begin
      m_inq.delete();
      for (int k = 0; k < SYNC; k++) m_inq.push_back(1'b0);
      m_clean = 0; m_rise = 0; m_fall = 0; m_los = 0;
      m_run = 0; m_timer = 0; m_gc = 0;
      return;
    end
    s = m_inq.pop_front();
    m_inq.push_back(IN);
    m_rise = 0; m_fall = 0;
    if (s != m_clean) begin
      m_run++;
      if (m_run >= FILT) begin
        m_clean = s; m_run = 0; m_timer = 0;
        m_rise = s & EN; m_fall = !s & EN;
      end else begin
        m_timer = (m_timer < LOSC) ? m_timer + 1 : LOSC;
      end
    end else begin
      if (m_run > 0 && EN && m_gc < 255) m_gc++;
      m_run = 0;
      m_timer = (m_timer < LOSC) ? m_timer + 1 : LOSC;
    end
    m_los = (m_timer == LOSC);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit i, input bit e);
    RST = r; IN = i; EN = e;
    @(posedge CLK);
    model_step();
    #1;
    chk("model_in_clean", IN_CLEAN, m_clean);
    chk("model_rise", RISE_PULSE, m_rise);
    chk("model_fall", FALL_PULSE, m_fall);
    chk("model_los", LOS, m_los);
    chk("model_gcnt", GLITCH_CNT, m_gc);
  endtask

  typedef struct {
    bit rst, din, en;
    bit clean, rise, fall, los;
    int gc;
  } vec_t;

  function automatic vec_t v(bit r, bit i, bit e, bit c, bit ri, bit f, bit l, int g);
    vec_t x;
    x.rst = r; x.din = i; x.en = e;
    x.clean = c; x.rise = ri; x.fall = f; x.los = l; x.gc = g;
    return x;
  endfunction

  initial begin
    vec_t tbl[22];
    int   rise_at, toggles, bad_pulse, bad_los;
    bit   prev_clean, cur_in;

    m_inq.delete();
    for (int k = 0; k < SYNC; k++) m_inq.push_back(1'b0);

    // Rise after 6 edges, fall after 6 more, then a 3-cycle glitch.
    tbl[0] = v(1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) tbl[k] = v(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[6] = v(0, 1, 1, 1, 1, 0, 0, 0);
    tbl[7] = v(0, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 8; k <= 12; k++) tbl[k] = v(0, 0, 1, 1, 0, 0, 0, 0);
    tbl[13] = v(0, 0, 1, 0, 0, 1, 0, 0);
    tbl[14] = v(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 15; k <= 17; k++) tbl[k] = v(0, 1, 1, 0, 0, 0, 0, 0);
    tbl[18] = v(0, 0, 1, 0, 0, 0, 0, 0);
    tbl[19] = v(0, 0, 1, 0, 0, 0, 0, 0);
    tbl[20] = v(0, 0, 1, 0, 0, 0, 0, 1);
    tbl[21] = v(0, 0, 1, 0, 0, 0, 0, 1);

    for (int k = 0; k < 22; k++) begin
      cycle(tbl[k].rst, tbl[k].din, tbl[k].en);
      chk($sformatf("tbl%0d_in_clean", k), IN_CLEAN, tbl[k].clean);
      chk($sformatf("tbl%0d_rise", k), RISE_PULSE, tbl[k].rise);
      chk($sformatf("tbl%0d_fall", k), FALL_PULSE, tbl[k].fall);
      chk($sformatf("tbl%0d_los", k), LOS, tbl[k].los);
      chk($sformatf("tbl%0d_gcnt", k), GLITCH_CNT, tbl[k].gc);
    end

    // Glitch counter saturation, then frozen while EN=0.
    cycle(1, 0, 1);
    for (int g = 0; g < 300; g++) begin
      repeat (3) cycle(0, 1, 1);
      repeat (4) cycle(0, 0, 1);
    end
    chk("gcnt_saturated", GLITCH_CNT, 255);
    chk("gcnt_sat_clean", IN_CLEAN, 0);
    for (int g = 0; g < 5; g++) begin
      repeat (3) cycle(0, 1, 0);
      repeat (4) cycle(0, 0, 0);
    end
    chk("gcnt_frozen", GLITCH_CNT, 255);

    // Loss of signal after 20 quiet cycles, cleared by the next accepted edge.
    cycle(1, 0, 1);
    for (int k = 1; k <= 25; k++) begin
      cycle(0, 0, 1);
      chk($sformatf("los_quiet%0d", k), LOS, (k >= LOSC) ? 1 : 0);
    end
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 1, 1);
      chk($sformatf("los_edge%0d", k), LOS, (k < 6) ? 1 : 0);
    end
    chk("los_edge_rise", RISE_PULSE, 1);

    // EN=0 square wave: level follows, no pulses, no LOS.
    cycle(1, 0, 1);
    toggles = 0; bad_pulse = 0; bad_los = 0; prev_clean = 0;
    for (int k = 0; k < 100; k++) begin
      cycle(0, ((k / 10) % 2) != 0, 0);
      if (IN_CLEAN !== prev_clean) toggles++;
      prev_clean = IN_CLEAN;
      if (RISE_PULSE || FALL_PULSE) bad_pulse++;
      if (LOS) bad_los++;
    end
    chk("sq_toggles_ge8", (toggles >= 8) ? 1 : 0, 1);
    chk("sq_no_pulses", bad_pulse, 0);
    chk("sq_no_los", bad_los, 0);

    // Reset shortly after IN rises aborts the filter; rise lands 6 edges after release.
    cycle(1, 0, 1);
    cycle(0, 1, 1);
    cycle(0, 1, 1);
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    chk("rst_in_clean", IN_CLEAN, 0);
    chk("rst_rise", RISE_PULSE, 0);
    chk("rst_fall", FALL_PULSE, 0);
    chk("rst_los", LOS, 0);
    chk("rst_gcnt", GLITCH_CNT, 0);
    rise_at = 0;
    for (int k = 1; k <= 20 && rise_at == 0; k++) begin
      cycle(0, 1, 1);
      if (RISE_PULSE) rise_at = k;
    end
    chk("rst_release_rise_edge", rise_at, SYNC + FILT);

    // Randomized run against the model.
    cycle(1, 0, 1);
    cur_in = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) cur_in = ~cur_in;
      cycle($urandom_range(0, 399) == 0, cur_in, $urandom_range(0, 7) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
